// File: rtl/key_debounce_if.sv
// Pushbutton conditioner signal bundle: raw key and repeat enable in,
// debounced level and one-cycle press/release pulses out.
interface key_debounce_if;
  logic key_raw;
  logic repeat_en;
  logic key_level;
  logic press_pulse;
  logic release_pulse;

  modport master (
    output key_raw,
    output repeat_en,
    input  key_level,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  key_raw,
    input  repeat_en,
    output key_level,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/key_debounce.sv
// Raw pushbutton conditioner: two-flop synchroniser, press/release debounce
// driven by one shared stability timer, and optional auto-repeat while held.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic           clk,
  input  logic           rst,
  key_debounce_if.slave  bus
);

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CYC = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] DEB_LAST   = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);
  localparam logic          IDLE_LEVEL = (ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          key_level_q, key_level_d;
  logic          press_pulse_q, press_pulse_d;
  logic          release_pulse_q, release_pulse_d;
  logic          pressed;
  logic [TW-1:0] timer_inc;

  assign pressed   = sync2_q ^ IDLE_LEVEL;
  assign timer_inc = timer_q + TW'(1);

  always_comb begin
    sync1_d         = bus.key_raw;
    sync2_d         = sync1_q;
    state_d         = state_q;
    timer_d         = timer_q;
    key_level_d     = key_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        key_level_d = 1'b0;
        if (pressed) begin
          state_d = PRESS_WAIT;
          timer_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d       = HELD;
          timer_d       = '0;
          key_level_d   = 1'b1;
          press_pulse_d = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      // With repeat disabled the timer parks at the delay limit, so enabling
      // repeat later fires immediately rather than wrapping the counter.
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          timer_d = '0;
        end else if (bus.repeat_en && (timer_q == DELAY_LAST)) begin
          state_d       = REPEAT;
          timer_d       = '0;
          press_pulse_d = 1'b1;
        end else if (timer_q != DELAY_LAST) begin
          timer_d = timer_inc;
        end
      end

      REPEAT: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          timer_d = '0;
        end else if (!bus.repeat_en) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == RATE_LAST) begin
          timer_d       = '0;
          press_pulse_d = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d         = IDLE;
          timer_d         = '0;
          key_level_d     = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: begin
        state_d     = IDLE;
        timer_d     = '0;
        key_level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q         <= IDLE_LEVEL;
      sync2_q         <= IDLE_LEVEL;
      state_q         <= IDLE;
      timer_q         <= '0;
      key_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      state_q         <= state_d;
      timer_q         <= timer_d;
      key_level_q     <= key_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign bus.key_level     = key_level_q;
  assign bus.press_pulse   = press_pulse_q;
  assign bus.release_pulse = release_pulse_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: an active-low and an active-high instance share
// one logical key stimulus and must produce identical pulse timing.
module tb_key_debounce;

  localparam int DEB   = 4;
  localparam int DELAY = 10;
  localparam int RATE  = 3;

  logic clk;
  logic rst;

  key_debounce_if kif_lo ();
  key_debounce_if kif_hi ();

  key_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_RATE     (RATE),
    .ACTIVE_LOW      (1)
  ) u_dut_lo (
    .clk (clk),
    .rst (rst),
    .bus (kif_lo.slave)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_RATE     (RATE),
    .ACTIVE_LOW      (0)
  ) u_dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (kif_hi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One segment of constant inputs held for a number of edges, with the
  // pulse counts expected over that segment and the level at its end.
  typedef struct packed {
    logic rst_n;
    logic key;
    logic rep;
    int   cycles;
    int   exp_press;
    int   exp_rel;
    logic exp_level;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs [NV];

  int checks;
  int passed;
  int press_lo, rel_lo, press_hi, rel_hi, overlap;

  task automatic check_output(input int row, input string what, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("[TB] FAIL row%0d %s: got %0d want %0d", row, what, got, want);
  endtask

  task automatic apply_stimulus(input vec_t v);
    press_lo = 0;
    rel_lo   = 0;
    press_hi = 0;
    rel_hi   = 0;
    overlap  = 0;
    for (int c = 0; c < v.cycles; c++) begin
      @(negedge clk);
      rst              = v.rst_n;
      kif_lo.key_raw   = ~v.key;
      kif_hi.key_raw   = v.key;
      kif_lo.repeat_en = v.rep;
      kif_hi.repeat_en = v.rep;
      @(posedge clk);
      #1;
      press_lo += int'(kif_lo.press_pulse);
      rel_lo   += int'(kif_lo.release_pulse);
      press_hi += int'(kif_hi.press_pulse);
      rel_hi   += int'(kif_hi.release_pulse);
      overlap  += int'(kif_lo.press_pulse & kif_lo.release_pulse);
      overlap  += int'(kif_hi.press_pulse & kif_hi.release_pulse);
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst              = 1'b0;
    kif_lo.key_raw   = 1'b1;
    kif_hi.key_raw   = 1'b0;
    kif_lo.repeat_en = 1'b0;
    kif_hi.repeat_en = 1'b0;

    //          rst  key  rep  cyc press rel level
    vecs[0]  = '{1'b0, 1'b0, 1'b0,  2, 0, 0, 1'b0};
    // clean press, pulse on edge 6, then release
    vecs[1]  = '{1'b1, 1'b1, 1'b0,  6, 0, 0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0,  1, 1, 0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0,  5, 0, 0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0,  6, 0, 0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0,  1, 0, 1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 13, 0, 0, 1'b0};
    // bounce 3 low / 2 high / 3 low
    vecs[7]  = '{1'b1, 1'b1, 1'b0,  3, 0, 0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0,  2, 0, 0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0,  3, 0, 0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0,  8, 0, 0, 1'b0};
    // auto-repeat: offsets 0,10,13,16,19,22,25,28
    vecs[11] = '{1'b1, 1'b1, 1'b1,  6, 0, 0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1,  1, 1, 0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b1,  9, 0, 0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 1'b1,  1, 1, 0, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 1'b1,  2, 0, 0, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 1'b1,  1, 1, 0, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 12, 4, 0, 1'b1};
    vecs[18] = '{1'b1, 1'b1, 1'b1,  3, 1, 0, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 1'b1,  2, 0, 0, 1'b1};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 15, 0, 0, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 1'b0,  7, 0, 1, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 1'b0,  3, 0, 0, 1'b0};
    // release glitch restarts the repeat delay
    vecs[23] = '{1'b1, 1'b1, 1'b1,  7, 1, 0, 1'b1};
    vecs[24] = '{1'b1, 1'b1, 1'b1,  3, 0, 0, 1'b1};
    vecs[25] = '{1'b1, 1'b0, 1'b1,  2, 0, 0, 1'b1};
    vecs[26] = '{1'b1, 1'b1, 1'b1, 12, 0, 0, 1'b1};
    vecs[27] = '{1'b1, 1'b1, 1'b1,  1, 1, 0, 1'b1};
    vecs[28] = '{1'b1, 1'b1, 1'b1,  2, 0, 0, 1'b1};
    // reset while held, then fresh debounce
    vecs[29] = '{1'b1, 1'b1, 1'b0,  3, 0, 0, 1'b1};
    vecs[30] = '{1'b0, 1'b1, 1'b0,  1, 0, 0, 1'b0};
    vecs[31] = '{1'b1, 1'b1, 1'b0,  6, 0, 0, 1'b0};
    vecs[32] = '{1'b1, 1'b1, 1'b0,  1, 1, 0, 1'b1};
    vecs[33] = '{1'b1, 1'b0, 1'b0,  7, 0, 1, 1'b0};
    vecs[34] = '{1'b1, 1'b0, 1'b0,  3, 0, 0, 1'b0};

    for (int r = 0; r < NV; r++) begin
      apply_stimulus(vecs[r]);
      check_output(r, "press_lo", press_lo, vecs[r].exp_press);
      check_output(r, "release_lo", rel_lo, vecs[r].exp_rel);
      check_output(r, "level_lo", int'(kif_lo.key_level), int'(vecs[r].exp_level));
      check_output(r, "press_hi", press_hi, vecs[r].exp_press);
      check_output(r, "release_hi", rel_hi, vecs[r].exp_rel);
      check_output(r, "level_hi", int'(kif_hi.key_level), int'(vecs[r].exp_level));
      check_output(r, "pulse_overlap", overlap, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
